data_mem_responder: RTL and testbench

//  Memory-side responder for CPU load/store requests: a big-endian, byte-addressed data RAM behind a

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_byte_array.sv | 41 ++++
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 tb/tb_data_mem_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder.
//   - Request size codes. They match the control unit's memRead field and are
//     also used for stores.
//   - FSM state encoding.
//   - format_load: turns a raw big-endian 4-byte read into the load result.
package dmem_pkg;

  localparam logic [1:0] SZ_ILLEGAL = 2'd0;
  localparam logic [1:0] SZ_WORD    = 2'd1;
  localparam logic [1:0] SZ_HALF    = 2'd2;
  localparam logic [1:0] SZ_HALFU   = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // raw[31:24] is the byte at the request address. A halfword therefore sits
  // in raw[31:16], and its sign is bit 31.
  function automatic logic [31:0] format_load(input logic [1:0] size,
                                              input logic [31:0] raw);
    logic [31:0] res;
    case (size)
      SZ_WORD:  res = raw;
      SZ_HALF:  res = {{16{raw[31]}}, raw[31:16]};
      SZ_HALFU: res = {16'h0000, raw[31:16]};
      default:  res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressed RAM with a big-endian 4-byte window.
// Ports:
//   clk    in   1   write clock
//   addr   in   32  byte address of lane 0 (lane 0 = bits [31:24])
//   we     in   4   per-lane write enable; lane i writes byte addr+i
//   wdata  in   32  write data, lane 0 in bits [31:24]
//   rdata  out  32  combinational read of bytes addr..addr+3
// A lane that falls past the end of the RAM reads as 0 and is never written.
// Contents are not reset.
module dmem_byte_array #(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic        clk,
  input  logic [31:0] addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  logic [7:0]  mem [DEPTH_BYTES];
  logic [32:0] lane_addr [4];
  logic [3:0]  lane_ok;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign lane_addr[gi] = {1'b0, addr} + 33'(gi);
    assign lane_ok[gi]   = lane_addr[gi] < 33'(DEPTH_BYTES);
    assign rdata[31-8*gi -: 8] = lane_ok[gi] ? mem[lane_addr[gi][AW-1:0]] : 8'h00;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i] && lane_ok[i]) begin
        mem[lane_addr[i][AW-1:0]] <= wdata[31-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for CPU load/store requests. It serves a big-endian
// byte RAM behind valid/ready request and response channels and has a fixed
// access latency.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready   request handshake; requests are accepted only in IDLE
//   req_write             1 = store, 0 = load
//   req_size              1 = word, 2 = half signed, 3 = half unsigned, 0 = illegal
//   req_addr, req_wdata   byte address and store data (stores are word only)
//   resp_valid/resp_ready response handshake; the data is held until taken
//   resp_rdata            load data, 0 for stores and errors
//   resp_error            request rejected, memory unchanged
//   busy                  high whenever the FSM is not IDLE
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  // The counter holds at most LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             error_q, error_d;

  logic [32:0] access_end;
  logic        access_err;
  logic        do_access;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;

  dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_ram (
    .clk   (clk),
    .addr  (addr_q),
    .we    (mem_we),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // Checks on the latched request. The end address is one past the last byte.
  always_comb begin
    access_end = {1'b0, addr_q} + ((size_q == SZ_WORD) ? 33'd4 : 33'd2);
    access_err = (size_q == SZ_ILLEGAL)
              || (write_q && (size_q != SZ_WORD))
              || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))
              || ((size_q != SZ_WORD) && addr_q[0])
              || (access_end > 33'(DEPTH_BYTES));
  end

  // The access happens on the last WAIT edge. A store commits on this same
  // edge, so any later load sees the new data.
  assign do_access = (state_q == ST_WAIT) && (cnt_q == '0);
  assign mem_we    = {4{do_access && write_q && !access_err}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          error_d = access_err;
          rdata_d = (access_err || write_q) ? 32'h0 : format_load(size_q, mem_rdata);
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      size_q  <= SZ_ILLEGAL;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: LATENCY=2
  logic        a_req_valid, a_req_ready, a_req_write;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_ready, a_resp_error, a_busy;
  logic [31:0] a_resp_rdata;

  // Instance B: LATENCY=1, resp_ready tied high
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_error, b_busy;
  logic [31:0] b_resp_rdata;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_size(a_req_size), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_error(a_resp_error), .busy(a_busy)
  );

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_size(b_req_size), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_error(b_resp_error), .busy(b_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[19];
  vec_t bvecs[6];

  // One full transaction on instance A with resp_ready high. Returns the
  // number of edges from accept to resp_valid.
  task automatic issue_a(input logic w, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd,
                         output logic er, output int lat);
    int guard;
    @(negedge clk);
    a_req_write = w; a_req_size = sz; a_req_addr = addr; a_req_wdata = wdata;
    a_req_valid = 1'b1;
    guard = 0;
    while (!a_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {31'b0, a_req_ready}, 32'd1);
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    lat = 0;
    do begin
      if (lat > 0) #1;
      @(posedge clk);
      lat++;
      #1;
    end while (!a_resp_valid && lat < 20);
    rd = a_resp_rdata;
    er = a_resp_error;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          g;
    int          k, r, cyc;
    int          acc_cyc[6];

    reset = 1'b0;
    a_req_valid = 0; a_req_write = 0; a_req_size = SZ_WORD; a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_write = 0; b_req_size = SZ_WORD; b_req_addr = 0; b_req_wdata = 0;
    a_resp_ready = 1'b1;
    b_resp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready",  {31'b0, a_req_ready},  32'd1);
    check("rst_resp_valid", {31'b0, a_resp_valid}, 32'd0);
    check("rst_rdata",      a_resp_rdata,          32'h0);
    check("rst_error",      {31'b0, a_resp_error}, 32'd0);
    check("rst_busy",       {31'b0, a_busy},       32'd0);
    check("rst_b_busy",     {31'b0, b_busy},       32'd0);
    reset = 1'b1;

    //            w     size        addr          wdata          rdata          err
    vecs[0]  = '{1'b1, SZ_WORD,    32'h10,       32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, SZ_WORD,    32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, SZ_HALF,    32'h10,       32'h0,        32'hFFFFDEAD, 1'b0};
    vecs[3]  = '{1'b0, SZ_HALFU,   32'h12,       32'h0,        32'h0000BEEF, 1'b0};
    vecs[4]  = '{1'b0, SZ_HALF,    32'h12,       32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[5]  = '{1'b0, SZ_WORD,    32'h11,       32'h0,        32'h00000000, 1'b1};
    vecs[6]  = '{1'b1, SZ_HALF,    32'h10,       32'h55555555, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, SZ_WORD,    DEPTH - 2,    32'h0,        32'h00000000, 1'b1};
    vecs[8]  = '{1'b0, SZ_WORD,    32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b0, SZ_ILLEGAL, 32'h0,        32'h0,        32'h00000000, 1'b1};
    vecs[10] = '{1'b1, SZ_WORD,    DEPTH - 4,    32'hA1B2C3D4, 32'h00000000, 1'b0};
    vecs[11] = '{1'b0, SZ_HALFU,   DEPTH - 2,    32'h0,        32'h0000C3D4, 1'b0};
    vecs[12] = '{1'b0, SZ_HALF,    DEPTH - 4,    32'h0,        32'hFFFFA1B2, 1'b0};
    vecs[13] = '{1'b0, SZ_HALF,    32'h13,       32'h0,        32'h00000000, 1'b1};
    vecs[14] = '{1'b1, SZ_WORD,    32'h20,       32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[15] = '{1'b0, SZ_WORD,    32'h20,       32'h0,        32'hCAFEF00D, 1'b0};
    vecs[16] = '{1'b1, SZ_WORD,    32'h22,       32'h0BADF00D, 32'h00000000, 1'b1};
    vecs[17] = '{1'b0, SZ_WORD,    32'h20,       32'h0,        32'hCAFEF00D, 1'b0};
    vecs[18] = '{1'b0, SZ_HALFU,   DEPTH,        32'h0,        32'h00000000, 1'b1};

    foreach (vecs[i]) begin
      issue_a(vecs[i].w, vecs[i].sz, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      $display("vec %0d w=%0d size=%0d addr=%h rdata=%h err=%0d lat=%0d",
               i, vecs[i].w, vecs[i].sz, vecs[i].addr, rd, er, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd2);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_error", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
    end

    // Response back-pressure, with a second request queued during RESP
    @(negedge clk);
    a_resp_ready = 1'b0;
    a_req_write = 1'b0; a_req_size = SZ_WORD; a_req_addr = 32'h10; a_req_valid = 1'b1;
    @(posedge clk);
    #1;
    a_req_size = SZ_HALFU; a_req_addr = 32'h12;
    g = 0;
    while (!a_resp_valid && g < 10) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("bp_resp_valid", {31'b0, a_resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_valid", i), {31'b0, a_resp_valid}, 32'd1);
      check($sformatf("bp_hold%0d_rdata", i), a_resp_rdata, 32'hDEADBEEF);
      check($sformatf("bp_hold%0d_req_ready", i), {31'b0, a_req_ready}, 32'd0);
    end
    $display("txn backpressure load 0x10 rdata=%h", a_resp_rdata);
    @(negedge clk);
    a_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_resp_valid", {31'b0, a_resp_valid}, 32'd0);
    check("bp_idle_req_ready",  {31'b0, a_req_ready},  32'd1);
    @(posedge clk);
    #1;
    check("bp_queued_busy",      {31'b0, a_busy},      32'd1);
    check("bp_queued_req_ready", {31'b0, a_req_ready}, 32'd0);
    a_req_valid = 1'b0;
    g = 0;
    while (!a_resp_valid && g < 10) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("bp_queued_valid", {31'b0, a_resp_valid}, 32'd1);
    check("bp_queued_rdata", a_resp_rdata, 32'h0000BEEF);
    $display("txn queued load halfu 0x12 rdata=%h", a_resp_rdata);
    @(posedge clk);
    #1;

    // Reset during WAIT drops the pending store
    @(negedge clk);
    a_req_write = 1'b1; a_req_size = SZ_WORD; a_req_addr = 32'h20;
    a_req_wdata = 32'h12345678; a_req_valid = 1'b1;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    check("wr_rst_busy_before", {31'b0, a_busy}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("wr_rst_req_ready",  {31'b0, a_req_ready},  32'd1);
    check("wr_rst_resp_valid", {31'b0, a_resp_valid}, 32'd0);
    check("wr_rst_rdata",      a_resp_rdata,          32'h0);
    check("wr_rst_error",      {31'b0, a_resp_error}, 32'd0);
    check("wr_rst_busy",       {31'b0, a_busy},       32'd0);
    @(negedge clk);
    reset = 1'b1;
    issue_a(1'b0, SZ_WORD, 32'h20, 32'h0, rd, er, lat);
    $display("txn post-reset load 0x20 rdata=%h err=%0d lat=%0d", rd, er, lat);
    check("wr_rst_load_rdata", rd, 32'hCAFEF00D);
    check("wr_rst_load_error", {31'b0, er}, 32'd0);

    // LATENCY=1 back-to-back stream on instance B
    bvecs[0] = '{1'b1, SZ_WORD,  32'h40, 32'h11223344, 32'h00000000, 1'b0};
    bvecs[1] = '{1'b0, SZ_WORD,  32'h40, 32'h0,        32'h11223344, 1'b0};
    bvecs[2] = '{1'b0, SZ_HALFU, 32'h42, 32'h0,        32'h00003344, 1'b0};
    bvecs[3] = '{1'b0, SZ_HALF,  32'h40, 32'h0,        32'h00001122, 1'b0};
    bvecs[4] = '{1'b1, SZ_WORD,  32'h44, 32'h8899AABB, 32'h00000000, 1'b0};
    bvecs[5] = '{1'b0, SZ_HALF,  32'h44, 32'h0,        32'hFFFF8899, 1'b0};
    k = 0; r = 0; cyc = 0;
    while (r < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (b_resp_valid) begin
        $display("txn B resp %0d rdata=%h err=%0d", r, b_resp_rdata, b_resp_error);
        check($sformatf("b_resp%0d_rdata", r), b_resp_rdata, bvecs[r].exp_rdata);
        check($sformatf("b_resp%0d_error", r), {31'b0, b_resp_error}, {31'b0, bvecs[r].exp_err});
        r++;
      end
      if (k < 6) begin
        b_req_write = bvecs[k].w; b_req_size = bvecs[k].sz;
        b_req_addr = bvecs[k].addr; b_req_wdata = bvecs[k].wdata;
        b_req_valid = 1'b1;
        if (b_req_ready) begin
          acc_cyc[k] = cyc;
          k++;
        end
      end else begin
        b_req_valid = 1'b0;
      end
    end
    b_req_valid = 1'b0;
    check("b_resp_count", r, 32'd6);
    for (int i = 1; i < 6; i++) begin
      if (i < k) check($sformatf("b_interval%0d", i), acc_cyc[i] - acc_cyc[i-1], 32'd3);
    end
    check("b_accept_count", k, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
